// File: rtl/lbist_wb_seq.sv
// lbist_wb_seq: Wishbone master that walks the LBIST register slave through
// one complete self-test. The sequence is soft reset, configure, release,
// start, poll STATUS until done, read SIG, compare it with the golden value,
// and finally write a stop. The whole block runs on wb_clk.
module lbist_wb_seq #(
    parameter int POLL_W = 16
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic              seq_start,
    input  logic              seq_abort,
    input  logic [15:0]       cfg_pat,
    input  logic [15:0]       cfg_depth,
    input  logic [31:0]       cfg_golden,
    input  logic [POLL_W-1:0] cfg_poll_gap,
    input  logic [POLL_W-1:0] cfg_poll_max,
    output logic              wb_cs,
    output logic [1:0]        wb_addr,
    output logic              wb_wr,
    output logic [31:0]       wb_wdata,
    output logic [3:0]        wb_be,
    input  logic [31:0]       wb_rdata,
    input  logic              wb_ack,
    input  logic              wb_err,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              seq_pass,
    output logic              seq_fail,
    output logic              seq_err,
    output logic [31:0]       seq_sig
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_CFG    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_SIG    = 2'd3;

    typedef enum logic [3:0] {
        IDLE,
        W_SRST,
        W_CFG,
        W_REL,
        W_GO,
        GAP,
        R_STAT,
        R_SIG,
        W_STOP,
        FIN
    } state_t;

    state_t            state_q, state_d;
    logic              cs_q, cs_d;
    logic [1:0]        addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              err_q, err_d;
    logic [31:0]       sig_q, sig_d;
    logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
    logic [POLL_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [15:0]       pat_q, pat_d;
    logic [15:0]       depth_q, depth_d;
    logic [31:0]       golden_q, golden_d;
    logic [POLL_W-1:0] poll_gap_q, poll_gap_d;
    logic [POLL_W-1:0] poll_max_q, poll_max_d;

    // Bus operation that belongs to the current state.
    logic [1:0]        op_addr;
    logic              op_wr;
    logic [31:0]       op_wdata;

    logic [POLL_W-1:0] poll_inc;
    logic [POLL_W-1:0] gap_inc;
    logic              poll_timeout;

    // The poll count saturates at its maximum value instead of wrapping.
    assign poll_inc     = (poll_cnt_q == {POLL_W{1'b1}}) ? poll_cnt_q : poll_cnt_q + POLL_W'(1);
    assign gap_inc      = gap_cnt_q + POLL_W'(1);
    assign poll_timeout = (poll_max_q != '0) && (poll_inc == poll_max_q);

    // Decode the register access that each bus state performs.
    always_comb begin
        op_addr  = ADDR_CTRL;
        op_wr    = 1'b1;
        op_wdata = 32'h0;
        case (state_q)
            W_SRST: op_wdata = 32'h2;
            W_CFG: begin
                op_addr  = ADDR_CFG;
                op_wdata = {depth_q, pat_q};
            end
            W_GO:   op_wdata = 32'h1;
            R_STAT: begin
                op_addr = ADDR_STATUS;
                op_wr   = 1'b0;
            end
            R_SIG: begin
                op_addr = ADDR_SIG;
                op_wr   = 1'b0;
            end
            default: ;
        endcase
    end

    // Next-state logic. A bus state raises cs in its first cycle, which is
    // when cs_q is still low. It then holds the request until the slave
    // answers. Because cs drops as the state advances, every transfer is
    // separated from the next by at least one idle cycle.
    always_comb begin
        state_d    = state_q;
        cs_d       = cs_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        fail_d     = fail_q;
        err_d      = err_q;
        sig_d      = sig_q;
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        pat_d      = pat_q;
        depth_d    = depth_q;
        golden_d   = golden_q;
        poll_gap_d = poll_gap_q;
        poll_max_d = poll_max_q;

        case (state_q)
            IDLE: begin
                if (seq_start) begin
                    pass_d     = 1'b0;
                    fail_d     = 1'b0;
                    err_d      = 1'b0;
                    poll_cnt_d = '0;
                    gap_cnt_d  = '0;
                    pat_d      = cfg_pat;
                    depth_d    = cfg_depth;
                    golden_d   = cfg_golden;
                    poll_gap_d = cfg_poll_gap;
                    poll_max_d = cfg_poll_max;
                    state_d    = W_SRST;
                end
            end

            GAP: begin
                if (seq_abort) begin
                    err_d     = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = W_STOP;
                end else if (gap_inc >= poll_gap_q) begin
                    gap_cnt_d = '0;
                    state_d   = R_STAT;
                end else begin
                    gap_cnt_d = gap_inc;
                end
            end

            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                if (!cs_q) begin
                    cs_d    = 1'b1;
                    addr_d  = op_addr;
                    wr_d    = op_wr;
                    wdata_d = op_wdata;
                end else if (wb_ack || wb_err) begin
                    cs_d = 1'b0;
                    if (wb_err) begin
                        // Only one cleanup stop is attempted. If the stop
                        // itself fails, the run ends anyway.
                        err_d   = 1'b1;
                        state_d = (state_q == W_STOP) ? FIN : W_STOP;
                    end else if (state_q == W_STOP) begin
                        state_d = FIN;
                    end else if (seq_abort) begin
                        err_d   = 1'b1;
                        state_d = W_STOP;
                    end else begin
                        case (state_q)
                            W_SRST: state_d = W_CFG;
                            W_CFG:  state_d = W_REL;
                            W_REL:  state_d = W_GO;
                            W_GO:   state_d = R_STAT;
                            R_STAT: begin
                                if (wb_rdata[0]) begin
                                    state_d = R_SIG;
                                end else begin
                                    poll_cnt_d = poll_inc;
                                    if (poll_timeout) begin
                                        err_d   = 1'b1;
                                        state_d = W_STOP;
                                    end else begin
                                        state_d = GAP;
                                    end
                                end
                            end
                            R_SIG: begin
                                sig_d = wb_rdata;
                                if (wb_rdata == golden_q) begin
                                    pass_d = 1'b1;
                                end else begin
                                    fail_d = 1'b1;
                                end
                                state_d = W_STOP;
                            end
                            default: state_d = W_STOP;
                        endcase
                    end
                end
            end
        endcase
    end

    // State and output registers. Reset is synchronous and active-high.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q    <= IDLE;
            cs_q       <= 1'b0;
            addr_q     <= 2'd0;
            wr_q       <= 1'b0;
            wdata_q    <= 32'h0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            err_q      <= 1'b0;
            sig_q      <= 32'h0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            pat_q      <= 16'h0;
            depth_q    <= 16'h0;
            golden_q   <= 32'h0;
            poll_gap_q <= '0;
            poll_max_q <= '0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            err_q      <= err_d;
            sig_q      <= sig_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            pat_q      <= pat_d;
            depth_q    <= depth_d;
            golden_q   <= golden_d;
            poll_gap_q <= poll_gap_d;
            poll_max_q <= poll_max_d;
        end
    end

    assign wb_cs    = cs_q;
    assign wb_addr  = addr_q;
    assign wb_wr    = wr_q;
    assign wb_wdata = wdata_q;
    assign wb_be    = 4'hF;
    assign seq_busy = (state_q != IDLE);
    assign seq_done = done_q;
    assign seq_pass = pass_q;
    assign seq_fail = fail_q;
    assign seq_err  = err_q;
    assign seq_sig  = sig_q;

endmodule

// File: tb/tb_lbist_wb_seq.sv
// Bench for lbist_wb_seq. A single process acts as the LBIST slave and
// drives the stimulus, advancing one negedge at a time. The expected
// transfer list and flags for each run come from the register-level rules.
module tb_lbist_wb_seq;

    localparam int POLL_W = 16;

    logic              wb_clk;
    logic              wb_rst;
    logic              seq_start;
    logic              seq_abort;
    logic [15:0]       cfg_pat;
    logic [15:0]       cfg_depth;
    logic [31:0]       cfg_golden;
    logic [POLL_W-1:0] cfg_poll_gap;
    logic [POLL_W-1:0] cfg_poll_max;
    logic              wb_cs;
    logic [1:0]        wb_addr;
    logic              wb_wr;
    logic [31:0]       wb_wdata;
    logic [3:0]        wb_be;
    logic [31:0]       wb_rdata;
    logic              wb_ack;
    logic              wb_err;
    logic              seq_busy;
    logic              seq_done;
    logic              seq_pass;
    logic              seq_fail;
    logic              seq_err;
    logic [31:0]       seq_sig;

    lbist_wb_seq #(.POLL_W(POLL_W)) dut (
        .wb_clk       (wb_clk),
        .wb_rst       (wb_rst),
        .seq_start    (seq_start),
        .seq_abort    (seq_abort),
        .cfg_pat      (cfg_pat),
        .cfg_depth    (cfg_depth),
        .cfg_golden   (cfg_golden),
        .cfg_poll_gap (cfg_poll_gap),
        .cfg_poll_max (cfg_poll_max),
        .wb_cs        (wb_cs),
        .wb_addr      (wb_addr),
        .wb_wr        (wb_wr),
        .wb_wdata     (wb_wdata),
        .wb_be        (wb_be),
        .wb_rdata     (wb_rdata),
        .wb_ack       (wb_ack),
        .wb_err       (wb_err),
        .seq_busy     (seq_busy),
        .seq_done     (seq_done),
        .seq_pass     (seq_pass),
        .seq_fail     (seq_fail),
        .seq_err      (seq_err),
        .seq_sig      (seq_sig)
    );

    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    int total_cnt;
    int bad_cnt;

    // Scenario knobs for the slave model.
    int          sc_done_after;
    logic [31:0] sc_sig;
    int          sc_err_on;
    int          sc_abort_at;
    int          sc_max_delay;

    // Slave and monitor state.
    int          cyc;
    int          xfer_idx;
    int          stat_reads;
    int          poll_idx;
    int          wait_cnt;
    bit          in_xfer;
    logic [63:0] cur_key;
    int          done_cnt;
    int          done_cyc;
    int          last_resp_cyc;
    int          run_base;

    // Expected results for the current run.
    logic [63:0] exp_q[$];
    int          exp_n;
    bit          exp_pass;
    bit          exp_fail;
    bit          exp_err;
    logic [31:0] exp_sig;
    logic [31:0] last_sig;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] want);
        total_cnt++;
        if (got !== want) begin
            bad_cnt++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] xfer_key(input logic wr, input logic [1:0] addr, input logic [31:0] data);
        return {29'd0, wr, addr, (wr ? data : 32'd0)};
    endfunction

    // One clock step: monitor seq_done and play the slave side of the bus.
    task automatic tick();
        logic [63:0] key;
        logic [31:0] rnd;
        @(negedge wb_clk);
        cyc++;
        if (seq_done) begin
            done_cnt++;
            done_cyc  = cyc;
            seq_abort = 1'b0;
        end
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        wb_rdata = 32'h0;
        if (!wb_cs || wb_rst) begin
            if (in_xfer && !wb_rst) check_value("cs_held", 64'(wb_cs), 64'd1);
            in_xfer = 1'b0;
        end else begin
            key = xfer_key(wb_wr, wb_addr, wb_wdata);
            if (!in_xfer) begin
                in_xfer  = 1'b1;
                xfer_idx++;
                cur_key  = key;
                wait_cnt = int'($urandom_range(sc_max_delay, 0));
                if (!wb_wr && wb_addr == 2'd2) begin
                    stat_reads++;
                    if (stat_reads == sc_abort_at) begin
                        seq_abort = 1'b1;
                        wait_cnt  = 5;
                    end
                end
                $display("xfer %0d: %s addr=%0d data=%h", xfer_idx, wb_wr ? "WR" : "RD", wb_addr, wb_wdata);
                check_value("be", 64'(wb_be), 64'hF);
                if (exp_q.size() == 0) check_value("xfer_count", 64'(xfer_idx), 64'(exp_n));
                else check_value($sformatf("xfer%0d", xfer_idx), key, exp_q.pop_front());
            end else begin
                check_value("xfer_stable", key, cur_key);
            end
            if (wait_cnt == 0) begin
                in_xfer       = 1'b0;
                last_resp_cyc = cyc;
                if (xfer_idx == sc_err_on) begin
                    wb_err = 1'b1;
                end else begin
                    wb_ack = 1'b1;
                    rnd    = $urandom();
                    if (!wb_wr && wb_addr == 2'd2) begin
                        poll_idx++;
                        wb_rdata = {rnd[31:1], (poll_idx >= sc_done_after)};
                    end else if (!wb_wr && wb_addr == 2'd3) begin
                        wb_rdata = sc_sig;
                    end else begin
                        wb_rdata = rnd;
                    end
                end
            end else begin
                wait_cnt--;
            end
        end
    endtask

    // Build the transfer list and the final flags from the register map rules.
    task automatic plan_run(input logic [15:0] pat, input logic [15:0] depth,
                            input logic [31:0] golden, input int pm, input bit abort_start);
        logic [63:0] q[$];
        bit timeout;
        bit sig_ok;
        int nreads;
        int sig_idx;
        int cut;
        q.delete();
        q.push_back(xfer_key(1'b1, 2'd0, 32'h2));
        q.push_back(xfer_key(1'b1, 2'd1, {depth, pat}));
        q.push_back(xfer_key(1'b1, 2'd0, 32'h0));
        q.push_back(xfer_key(1'b1, 2'd0, 32'h1));
        timeout = (pm != 0) && (sc_done_after - 1 >= pm);
        nreads  = timeout ? pm : sc_done_after;
        for (int i = 0; i < nreads; i++) q.push_back(xfer_key(1'b0, 2'd2, 32'h0));
        sig_idx = 0;
        if (!timeout) begin
            q.push_back(xfer_key(1'b0, 2'd3, 32'h0));
            sig_idx = q.size();
        end
        q.push_back(xfer_key(1'b1, 2'd0, 32'h0));
        exp_err = timeout;
        sig_ok  = !timeout;
        cut = 0;
        if (abort_start) cut = 1;
        else if (sc_abort_at > 0 && sc_abort_at <= nreads) cut = 4 + sc_abort_at;
        if (cut > 0) begin
            while (q.size() > cut) void'(q.pop_back());
            q.push_back(xfer_key(1'b1, 2'd0, 32'h0));
            exp_err = 1'b1;
            sig_ok  = 1'b0;
        end else if (sc_err_on > 0 && sc_err_on <= q.size()) begin
            exp_err = 1'b1;
            if (sc_err_on <= sig_idx) sig_ok = 1'b0;
            if (sc_err_on < q.size()) begin
                while (q.size() > sc_err_on) void'(q.pop_back());
                q.push_back(xfer_key(1'b1, 2'd0, 32'h0));
            end
        end
        exp_pass = sig_ok && (sc_sig == golden);
        exp_fail = sig_ok && (sc_sig != golden);
        exp_sig  = sig_ok ? sc_sig : last_sig;
        exp_n    = q.size();
        exp_q    = q;
    endtask

    task automatic start_run(input logic [15:0] pat, input logic [15:0] depth,
                             input logic [31:0] golden, input logic [31:0] sig,
                             input int done_after, input int gap, input int pm,
                             input int err_on, input int abort_at, input bit abort_start,
                             input int max_delay);
        sc_done_after = done_after;
        sc_sig        = sig;
        sc_err_on     = err_on;
        sc_abort_at   = abort_at;
        sc_max_delay  = max_delay;
        xfer_idx      = 0;
        stat_reads    = 0;
        poll_idx      = 0;
        run_base      = done_cnt;
        plan_run(pat, depth, golden, pm, abort_start);
        cfg_pat      = pat;
        cfg_depth    = depth;
        cfg_golden   = golden;
        cfg_poll_gap = POLL_W'(gap);
        cfg_poll_max = POLL_W'(pm);
        seq_start    = 1'b1;
        if (abort_start) seq_abort = 1'b1;
        tick();
        seq_start = 1'b0;
        tick();
        tick();
        // Restart attempt and cfg change while busy must both be ignored.
        check_value("busy_mid", 64'(seq_busy), 64'd1);
        seq_start    = 1'b1;
        cfg_pat      = 16'($urandom());
        cfg_depth    = 16'($urandom());
        cfg_golden   = $urandom();
        cfg_poll_gap = POLL_W'($urandom_range(5, 0));
        cfg_poll_max = POLL_W'(1);
        tick();
        seq_start = 1'b0;
    endtask

    task automatic end_run(input string name);
        int guard;
        guard = 0;
        while (done_cnt == run_base && guard < 4000) begin
            tick();
            guard++;
        end
        tick();
        tick();
        tick();
        $display("run %s: xfers=%0d pass=%0d fail=%0d err=%0d sig=%h",
                 name, xfer_idx, seq_pass, seq_fail, seq_err, seq_sig);
        check_value({name, "_done"}, 64'(done_cnt - run_base), 64'd1);
        check_value({name, "_nxfer"}, 64'(xfer_idx), 64'(exp_n));
        check_value({name, "_pass"}, 64'(seq_pass), 64'(exp_pass));
        check_value({name, "_fail"}, 64'(seq_fail), 64'(exp_fail));
        check_value({name, "_err"}, 64'(seq_err), 64'(exp_err));
        check_value({name, "_sig"}, 64'(seq_sig), 64'(exp_sig));
        check_value({name, "_busy"}, 64'(seq_busy), 64'd0);
        check_value({name, "_done_lat"}, 64'(done_cyc - last_resp_cyc), 64'd2);
        last_sig = exp_sig;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_value({tag, "_cs"}, 64'(wb_cs), 64'd0);
        check_value({tag, "_wr"}, 64'(wb_wr), 64'd0);
        check_value({tag, "_addr"}, 64'(wb_addr), 64'd0);
        check_value({tag, "_wdata"}, 64'(wb_wdata), 64'd0);
        check_value({tag, "_be"}, 64'(wb_be), 64'hF);
        check_value({tag, "_busy"}, 64'(seq_busy), 64'd0);
        check_value({tag, "_done"}, 64'(seq_done), 64'd0);
        check_value({tag, "_pass"}, 64'(seq_pass), 64'd0);
        check_value({tag, "_fail"}, 64'(seq_fail), 64'd0);
        check_value({tag, "_err"}, 64'(seq_err), 64'd0);
        check_value({tag, "_sig"}, 64'(seq_sig), 64'd0);
    endtask

    initial begin
        int guard;
        int cs_seen;
        logic [31:0] golden;
        logic [31:0] sig;
        total_cnt    = 0;
        bad_cnt      = 0;
        cyc          = 0;
        xfer_idx     = 0;
        stat_reads   = 0;
        poll_idx     = 0;
        wait_cnt     = 0;
        in_xfer      = 1'b0;
        cur_key      = '0;
        done_cnt     = 0;
        done_cyc     = 0;
        last_resp_cyc = 0;
        run_base     = 0;
        exp_n        = 0;
        last_sig     = 32'h0;
        sc_done_after = 1;
        sc_sig       = 32'h0;
        sc_err_on    = 0;
        sc_abort_at  = 0;
        sc_max_delay = 0;
        wb_rst       = 1'b1;
        seq_start    = 1'b0;
        seq_abort    = 1'b0;
        cfg_pat      = 16'h0;
        cfg_depth    = 16'h0;
        cfg_golden   = 32'h0;
        cfg_poll_gap = '0;
        cfg_poll_max = '0;
        wb_ack       = 1'b0;
        wb_err       = 1'b0;
        wb_rdata     = 32'h0;

        repeat (3) tick();
        check_idle_outputs("rst");
        wb_rst = 1'b0;
        tick();

        start_run(16'h0040, 16'h0010, 32'hA5A5_1234, 32'hA5A5_1234, 3, 2, 0, 0, 0, 1'b0, 0);
        end_run("nominal");
        start_run(16'h0040, 16'h0010, 32'hA5A5_1234, 32'hA5A5_1235, 3, 2, 0, 0, 0, 1'b0, 1);
        end_run("sig_miss");
        start_run(16'h1234, 16'h0008, 32'h0BAD_F00D, 32'h0BAD_F00D, 1000, 1, 4, 0, 0, 1'b0, 0);
        end_run("timeout");
        start_run(16'h0040, 16'h0010, 32'hA5A5_1234, 32'hA5A5_1234, 3, 0, 0, 2, 0, 1'b0, 0);
        end_run("bus_err");
        start_run(16'h0040, 16'h0010, 32'hA5A5_1234, 32'hA5A5_1234, 1000, 3, 0, 0, 2, 1'b0, 0);
        end_run("abort");
        start_run(16'h0040, 16'h0010, 32'hA5A5_1234, 32'hA5A5_1234, 3, 0, 0, 0, 0, 1'b1, 0);
        end_run("abort_start");

        // Reset while the sequencer sits in GAP between status reads.
        start_run(16'h0040, 16'h0010, 32'hA5A5_1234, 32'hA5A5_1234, 1000, 8, 0, 0, 0, 1'b0, 0);
        guard = 0;
        while (!(stat_reads >= 2 && !in_xfer) && guard < 500) begin
            tick();
            guard++;
        end
        check_value("gap_reach", 64'(stat_reads), 64'd2);
        tick();
        wb_rst = 1'b1;
        tick();
        check_idle_outputs("gap_rst");
        wb_rst = 1'b0;
        exp_q.delete();
        last_sig = 32'h0;
        cs_seen  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wb_cs) cs_seen++;
        end
        check_value("gap_rst_quiet", 64'(cs_seen), 64'd0);
        check_value("gap_rst_nodone", 64'(done_cnt - run_base), 64'd0);

        start_run(16'h0040, 16'h0010, 32'hA5A5_1234, 32'hA5A5_1234, 3, 2, 0, 0, 0, 1'b0, 0);
        end_run("restart");

        for (int r = 0; r < 20; r++) begin
            golden = $urandom();
            sig    = ($urandom_range(1, 0) == 1) ? golden : (golden ^ (32'h1 << $urandom_range(31, 0)));
            start_run(16'($urandom()), 16'($urandom()), golden, sig,
                      int'($urandom_range(5, 1)), int'($urandom_range(3, 0)),
                      int'($urandom_range(5, 0)),
                      ($urandom_range(3, 0) == 0) ? int'($urandom_range(10, 1)) : 0,
                      0, 1'b0, int'($urandom_range(2, 0)));
            end_run($sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/lbist_wb_seq.md
# lbist_wb_seq

Wishbone-master sequencer that drives the LBIST register slave through a full self-test run. On a single start pulse it software-resets the LBIST, programs pattern count and chain depth, starts the test, polls for completion, reads the signature and compares it against a golden value. It sits on the wb_clk side of the LBIST wrapper and replaces firmware-driven LBIST bring-up.

## Interface
- POLL_W, 16: width of the poll-gap counter and the poll-limit counter.
- wb_clk  in  1  clock; all logic is single-clock.
- wb_rst  in  1  synchronous reset, active-high.
- seq_start  in  1  one-cycle pulse; ignored unless the FSM is in IDLE.
- seq_abort  in  1  level; requests a stop run (see Operation).
- cfg_pat  in  16  pattern count written to LBIST.
- cfg_depth  in  16  chain depth written to LBIST.
- cfg_golden  in  32  expected signature.
- cfg_poll_gap  in  POLL_W  idle cycles between status reads.
- cfg_poll_max  in  POLL_W  maximum status reads before timeout; 0 means unlimited.
- wb_cs  out  1  bus request.
- wb_addr  out  2  register address.
- wb_wr  out  1  1 = write.
- wb_wdata  out  32  write data.
- wb_be  out  4  byte enables; always 4'hF.
- wb_rdata  in  32  read data, valid with wb_ack.
- wb_ack  in  1  transfer complete.
- wb_err  in  1  transfer error or timeout.
- seq_busy  out  1  FSM is not in IDLE.
- seq_done  out  1  one-cycle pulse at the end of any run.
- seq_pass  out  1  sticky; set when the signature matches.
- seq_fail  out  1  sticky; set when the signature mismatches.
- seq_err  out  1  sticky; set on bus error, poll timeout or abort.
- seq_sig  out  32  last signature read.

## Operation
- LBIST register map:
  - Address 0 is CTRL: bit0 = start, bit1 = software reset.
  - Address 1 is CFG: bits [31:16] = depth, bits [15:0] = pat.
  - Address 2 is STATUS: bit0 = done.
  - Address 3 is SIG.
- FSM states, in order: IDLE, W_SRST, W_CFG, W_REL, W_GO, GAP, R_STAT, R_SIG, W_STOP, FIN.
- Writes performed in each state:
  - W_SRST writes CTRL = 32'h2.
  - W_CFG writes CFG = {cfg_depth, cfg_pat}.
  - W_REL writes CTRL = 32'h0.
  - W_GO writes CTRL = 32'h1.
  - W_STOP writes CTRL = 32'h0.
- R_STAT reads STATUS.
  - If bit0 = 1, go to R_SIG.
  - Otherwise increment the poll count. If cfg_poll_max != 0 and the count equals cfg_poll_max, set seq_err and go to W_STOP. Otherwise go to GAP.
- GAP counts cfg_poll_gap cycles, then goes to R_STAT. With cfg_poll_gap = 0, the read is issued on the next cycle.
- R_SIG captures wb_rdata into seq_sig.
  - wb_rdata == cfg_golden sets seq_pass.
  - Otherwise seq_fail is set.
  - Then go to W_STOP.
- W_STOP is followed by FIN. FIN pulses seq_done and returns to IDLE.
- seq_start in IDLE clears seq_pass, seq_fail, seq_err and the poll count, latches all cfg_* inputs, and enters W_SRST. cfg_* changes during a run have no effect.
- wb_err on any transfer sets seq_err and ends the run:
  - During W_STOP, go to FIN.
  - In any other state, go to W_STOP (a single cleanup attempt).
- seq_abort while in GAP, or when an in-flight transfer completes, sets seq_err and goes to W_STOP. Abort never truncates an active transfer.
- seq_start while busy is ignored. seq_start and seq_abort asserted together in IDLE: start wins; the abort is then honoured at the first transfer completion.

## Timing
- Bus handshake:
  - wb_cs asserts the cycle after state entry, with addr, wr and wdata registered and stable.
  - The request is held until wb_ack or wb_err is sampled high.
  - wb_cs drops in the following cycle. There is at least one cycle of wb_cs = 0 between transfers.
  - wb_ack and wb_err are ignored while wb_cs = 0.
- Read data is sampled on the wb_ack cycle only.
- There is no bus timeout inside this block; the slave-side timeout reports through wb_err.
- Nominal run with single-cycle ack and a STATUS already done on the first poll: 7 transfers. seq_done rises 2 cycles after the last ack.
- Reset values:
  - wb_cs, wb_wr, wb_addr, wb_wdata = 0.
  - wb_be = 4'hF.
  - seq_busy, seq_done, seq_pass, seq_fail, seq_err = 0.
  - seq_sig = 0.
  - FSM state = IDLE.
- wb_rst mid-transfer drops wb_cs on the next edge. No cleanup write is issued.
- The poll counter saturates at its maximum value and does not wrap.

## Test plan
- Nominal pass:
  - Stimulus: pat = 16'h0040, depth = 16'h0010, golden = 32'hA5A5_1234. The slave model returns done after 3 polls with SIG = 32'hA5A5_1234.
  - Required: write sequence CTRL = 2, CFG = 32'h0010_0040, CTRL = 0, CTRL = 1; then 3 STATUS reads, 1 SIG read, CTRL = 0. seq_pass = 1, seq_done pulses once.
- Mismatch: SIG = 32'hA5A5_1235 -> seq_fail = 1, seq_pass = 0, seq_sig = 32'hA5A5_1235.
- Poll timeout: poll_max = 4, done never asserted -> exactly 4 STATUS reads, then CTRL = 0, seq_err = 1, no SIG read.
- Bus error: wb_err on the W_CFG transfer -> seq_err = 1; the next transfer is CTRL = 0; seq_done pulses.
- Abort: seq_abort asserted mid-R_STAT with ack delayed 5 cycles -> wb_cs is held until ack, then the CTRL = 0 write, seq_err = 1.
- Reset and restart:
  - wb_rst asserted during GAP -> all outputs return to reset values the next cycle.
  - A subsequent seq_start runs nominally.
  - seq_start pulsed while busy causes no restart.
